dmx_rx_capture: RTL

DMX_RX_CAPTURE -- requirements
Module: dmx_rx_capture

---
 rtl/dmx_pkg.sv | 26 ++
 rtl/dmx_rx_capture_if.sv | 32 +++
 rtl/dmx_rx_sync.sv | 24 ++
 rtl/dmx_rx_capture.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dmx_pkg.sv
// DMX512 shared definitions: receiver state encoding and line timing.
// Also used by the DMX output side so both ends agree on break/MAB lengths.
package dmx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BREAK,
    MAB,
    START,
    DATA,
    STOP,
    ERROR
  } dmx_state_t;

  localparam int unsigned BREAK_US  = 88;
  localparam int unsigned MAB_US    = 8;
  localparam int unsigned SLOT_BITS = 11;

  function automatic int unsigned us_to_clk(
    input int unsigned clk_freq,
    input int unsigned us
  );
    return clk_freq / 1000 * us / 1000;
  endfunction

endpackage

// File: rtl/dmx_rx_capture_if.sv
// DMX receiver bus: raw line in, captured frame and status out.
// master = line/consumer side, slave = receiver.
interface dmx_rx_capture_if #(
  parameter int unsigned DMX_BUFFER_SIZE = 513
);

  logic                         dmx_in;
  logic [8*DMX_BUFFER_SIZE-1:0] dmx_data;
  logic [9:0]                   n_bytes;
  logic                         signal_enabled;
  logic                         frame_done;
  logic                         frame_err;

  modport master (
    output dmx_in,
    input  dmx_data,
    input  n_bytes,
    input  signal_enabled,
    input  frame_done,
    input  frame_err
  );

  modport slave (
    input  dmx_in,
    output dmx_data,
    output n_bytes,
    output signal_enabled,
    output frame_done,
    output frame_err
  );

endinterface

// File: rtl/dmx_rx_sync.sv
// Two-flop synchronizer for the asynchronous RS-485 line, plus
// rising/falling edge detect on the synchronized value.
module dmx_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rx,
  output logic rise,
  output logic fall
);

  // sh[1] is the synchronized line, sh[2] its previous value
  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh <= '1;
    else        sh <= {sh[1:0], din};
  end

  assign rx   = sh[1];
  assign rise = sh[1] & ~sh[2];
  assign fall = ~sh[1] & sh[2];

endmodule

// File: rtl/dmx_rx_capture.sv
// DMX512 frame receiver: break/MAB detect, 8N2 slot decode into a
// slot buffer, frame-complete and loss-of-signal status.
module dmx_rx_capture
  import dmx_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = 12_000_000,
  parameter int unsigned BAUD_RATE       = 250_000,
  parameter int unsigned DMX_BUFFER_SIZE = 513,
  parameter int unsigned TIMEOUT_MS      = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  dmx_rx_capture_if.slave bus
);

  localparam int unsigned BIT_TIME  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT  = BIT_TIME / 2;
  localparam int unsigned BREAK_MIN = us_to_clk(CLK_FREQ, BREAK_US);
  localparam int unsigned MAB_MIN   = us_to_clk(CLK_FREQ, MAB_US);
  localparam int unsigned IDLE_END  = 2 * SLOT_BITS * BIT_TIME;
  localparam int unsigned TO_CLKS   = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam logic [9:0]  SLOTS     = 10'(DMX_BUFFER_SIZE);

  dmx_state_t                   state;
  logic [8*DMX_BUFFER_SIZE-1:0] data_q;
  logic [9:0]                   n_q;
  logic [9:0]                   idx;
  logic                         sig_q;
  logic                         done_q;
  logic                         err_q;
  logic [31:0]                  cnt;
  logic [31:0]                  low_cnt;
  logic [31:0]                  to_cnt;
  logic [7:0]                   shreg;
  logic [2:0]                   bit_cnt;
  logic                         wait_slot;
  logic                         brk_pend;
  logic                         rx;
  logic                         rise;
  logic                         fall;
  logic                         brk_hit;

  dmx_rx_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (bus.dmx_in),
    .rx   (rx),
    .rise (rise),
    .fall (fall)
  );

  assign brk_hit = !rx && (low_cnt == BREAK_MIN - 1);

  assign bus.dmx_data       = data_q;
  assign bus.n_bytes        = n_q;
  assign bus.signal_enabled = sig_q;
  assign bus.frame_done     = done_q;
  assign bus.frame_err      = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      data_q    <= '0;
      n_q       <= '0;
      idx       <= '0;
      sig_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt       <= '0;
      low_cnt   <= '0;
      to_cnt    <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      wait_slot <= 1'b0;
      brk_pend  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      if (rx)                         low_cnt <= '0;
      else if (low_cnt != BREAK_MIN)  low_cnt <= low_cnt + 32'd1;

      if (to_cnt == TO_CLKS - 1) sig_q  <= 1'b0;
      else                       to_cnt <= to_cnt + 32'd1;

      // A long low wins from any state; a pending frame is closed first
      if (brk_hit && state != BREAK) begin
        if (idx != '0) begin
          n_q    <= idx;
          done_q <= 1'b1;
          to_cnt <= '0;
        end
        state     <= BREAK;
        sig_q     <= 1'b0;
        idx       <= '0;
        wait_slot <= 1'b0;
        brk_pend  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: cnt <= '0;
          BREAK: begin
            if (rise) begin
              state <= MAB;
              cnt   <= 32'd1;
            end
          end
          MAB: begin
            if (fall) begin
              cnt <= '0;
              if (cnt >= MAB_MIN) begin
                state <= START;
              end else begin
                state <= ERROR;
                err_q <= 1'b1;
              end
            end else if (rx && cnt != MAB_MIN) begin
              cnt <= cnt + 32'd1;
            end
          end
          START: begin
            if (cnt == HALF_BIT - 1) begin
              cnt <= '0;
              if (!rx) begin
                state   <= DATA;
                bit_cnt <= '0;
              end else begin
                state     <= STOP;
                wait_slot <= 1'b1;
              end
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          DATA: begin
            if (cnt == BIT_TIME - 1) begin
              cnt     <= '0;
              shreg   <= {rx, shreg[7:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= STOP;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          STOP: begin
            if (wait_slot) begin
              if (fall && idx != SLOTS) begin
                state     <= START;
                cnt       <= '0;
                wait_slot <= 1'b0;
              end else if (idx == SLOTS || cnt == IDLE_END - 1) begin
                if (idx != '0) begin
                  n_q    <= idx;
                  sig_q  <= 1'b1;
                  done_q <= 1'b1;
                  to_cnt <= '0;
                end
                state     <= IDLE;
                idx       <= '0;
                cnt       <= '0;
                wait_slot <= 1'b0;
              end else begin
                cnt <= cnt + 32'd1;
              end
            end else if (cnt == BIT_TIME - 1) begin
              cnt <= '0;
              if (rx) begin
                if (idx < SLOTS) data_q[8*idx +: 8] <= shreg;
                idx       <= idx + 10'd1;
                wait_slot <= 1'b1;
              end else begin
                state <= ERROR;
                // An all-zero slot with low stop may be the next break
                if (shreg == 8'h00) begin
                  brk_pend <= 1'b1;
                end else begin
                  err_q <= 1'b1;
                  idx   <= '0;
                end
              end
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          ERROR: begin
            if (rx) begin
              state    <= IDLE;
              idx      <= '0;
              err_q    <= brk_pend;
              brk_pend <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
